// File: rtl/spi_pkg.sv
// Shared SPI transfer definitions: the transfer state encoding and default
// geometry, reused by the acquisition sequencer and the bench.
package spi_pkg;

    localparam int SPI_DATA_WIDTH = 16;
    localparam int SPI_EXP_FACTOR = 6;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } spi_xfer_state_t;

endpackage

// File: rtl/spi_xfer_ctrl_edge.sv
// SCLK phase generator: free-runs a phase counter while enabled and flags the
// clock edges on which SCLK is about to rise or fall.
module spi_edge_strobe
    import spi_pkg::*;
#(
    parameter int EXP_FACTOR = SPI_EXP_FACTOR
) (
    input  logic clock_i,
    input  logic reset_ni,
    input  logic en,
    output logic rise_stb,
    output logic fall_stb,
    output logic sclk
);

    localparam int HALF = 1 << (EXP_FACTOR - 1);
    localparam logic [EXP_FACTOR-1:0] PH_RISE = EXP_FACTOR'(HALF - 1);
    localparam logic [EXP_FACTOR-1:0] PH_FALL = '1;

    logic [EXP_FACTOR-1:0] ph;
    logic [EXP_FACTOR-1:0] ph_nxt;

    assign ph_nxt   = ph + EXP_FACTOR'(1);
    assign rise_stb = en && (ph == PH_RISE);
    assign fall_stb = en && (ph == PH_FALL);

    // SCLK is the counter MSB registered one step ahead, so it stays glitch-free
    // and is forced low the moment the enable drops.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ph   <= '0;
            sclk <= 1'b0;
        end else if (en) begin
            ph   <= ph_nxt;
            sclk <= ph_nxt[EXP_FACTOR-1];
        end else begin
            ph   <= '0;
            sclk <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Single SPI mode-0 transfer sequencer: CS setup, bit-counted shift of one
// word out MSB-first while capturing the reply, CS hold, then a done pulse.
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH      = SPI_DATA_WIDTH,
    parameter int EXP_FACTOR      = SPI_EXP_FACTOR,
    parameter int CS_SETUP_CYCLES = 4,
    parameter int CS_HOLD_CYCLES  = 4
) (
    input  logic                  clock_i,
    input  logic                  reset_ni,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  SCLK_o,
    output logic                  CSn_o,
    output logic                  MOSI_o,
    input  logic                  MISO_i
);

    localparam int CNT_MAX = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ? CS_SETUP_CYCLES : CS_HOLD_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(DATA_WIDTH + 1);

    spi_xfer_state_t state, state_nxt;

    logic [CW-1:0]         cnt, cnt_nxt;
    logic [BW-1:0]         bit_cnt, bit_cnt_nxt;
    logic                  load_tx;
    logic                  finish;
    logic                  en;
    logic                  rise_stb;
    logic                  fall_stb;
    logic                  last_bit;
    logic [DATA_WIDTH-1:0] tx_sr, tx_shl;
    logic [DATA_WIDTH-1:0] rx_sr, rx_shl;

    assign en       = (state == SHIFT);
    assign last_bit = (int'(bit_cnt) == DATA_WIDTH - 1);

    spi_edge_strobe #(
        .EXP_FACTOR (EXP_FACTOR)
    ) u_edge (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .en       (en),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .sclk     (SCLK_o)
    );

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_cnt_nxt = bit_cnt;
        load_tx     = 1'b0;
        finish      = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    load_tx     = 1'b1;
                    cnt_nxt     = '0;
                    bit_cnt_nxt = '0;
                    state_nxt   = SETUP;
                end
            end
            SETUP: begin
                if (int'(cnt) == CS_SETUP_CYCLES - 1) begin
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            SHIFT: begin
                if (fall_stb) begin
                    bit_cnt_nxt = bit_cnt + BW'(1);
                    if (last_bit) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (int'(cnt) == CS_HOLD_CYCLES - 1) begin
                    cnt_nxt   = '0;
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx_shl    = tx_sr << 1;
        rx_shl    = rx_sr << 1;
        rx_shl[0] = MISO_i;
    end

    // Shift registers carry no reset: every bit is overwritten before it is used.
    always_ff @(posedge clock_i) begin
        if (load_tx) begin
            tx_sr <= tx_data_i;
        end else if (fall_stb) begin
            tx_sr <= tx_shl;
        end
        if (rise_stb) begin
            rx_sr <= rx_shl;
        end
    end

    // Pin-facing outputs are registered from next-state decode.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            busy_o    <= 1'b0;
            CSn_o     <= 1'b1;
            MOSI_o    <= 1'b0;
            done_o    <= 1'b0;
            rx_data_o <= '0;
        end else begin
            busy_o <= (state_nxt != IDLE);
            CSn_o  <= (state_nxt == IDLE);
            done_o <= finish;
            if (finish) begin
                rx_data_o <= rx_sr;
            end
            if (load_tx) begin
                MOSI_o <= tx_data_i[DATA_WIDTH-1];
            end else if (fall_stb) begin
                MOSI_o <= tx_shl[DATA_WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Scoreboard bench for spi_xfer_ctrl: a default-geometry instance with a mode-0
// slave model, plus a minimal 1-bit instance wired in loopback.
module tb_spi_xfer_ctrl;

    typedef struct {
        logic [15:0] tx;
        logic [15:0] rx;
        int          done_cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic [15:0] tx;
    logic        busy, done, sclk, csn, mosi, miso;
    logic [15:0] rx;

    logic       cstart;
    logic [0:0] ctx;
    logic       cbusy, cdone, csclk, ccsn, cmosi;
    logic [0:0] crx;
    logic [0:0] cmiso;

    spi_xfer_ctrl dut (
        .clock_i   (clk),
        .reset_ni  (rst_n),
        .start_i   (start),
        .tx_data_i (tx),
        .busy_o    (busy),
        .done_o    (done),
        .rx_data_o (rx),
        .SCLK_o    (sclk),
        .CSn_o     (csn),
        .MOSI_o    (mosi),
        .MISO_i    (miso)
    );

    spi_xfer_ctrl #(
        .DATA_WIDTH      (1),
        .EXP_FACTOR      (1),
        .CS_SETUP_CYCLES (1),
        .CS_HOLD_CYCLES  (1)
    ) dut_c (
        .clock_i   (clk),
        .reset_ni  (rst_n),
        .start_i   (cstart),
        .tx_data_i (ctx),
        .busy_o    (cbusy),
        .done_o    (cdone),
        .rx_data_o (crx),
        .SCLK_o    (csclk),
        .CSn_o     (ccsn),
        .MOSI_o    (cmosi),
        .MISO_i    (cmiso)
    );

    assign cmiso = cmosi;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    exp_t sbq[$];
    exp_t cq[$];
    exp_t m_e, c_e;

    logic [15:0] slave_word = 16'h0;
    logic [15:0] slave_sr   = 16'h0;
    logic [15:0] mosi_word  = 16'h0;
    int rise_cnt     = 0;
    int done_count   = 0;
    int csn_hi_run   = 0;
    int last_gap     = 0;
    int sclk_toggles = 0;
    int csn_low_cnt  = 0;
    int c_hi         = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc++;

    // Mode-0 slave: presents its MSB when CS falls, advances on SCLK falls.
    always @(negedge csn) begin
        slave_sr  = slave_word;
        miso      = slave_sr[15];
        mosi_word = 16'h0;
        rise_cnt  = 0;
    end
    always @(negedge sclk) begin
        if (csn === 1'b0) begin
            slave_sr = slave_sr << 1;
            miso     = slave_sr[15];
        end
    end
    always @(posedge sclk) begin
        mosi_word = {mosi_word[14:0], mosi};
        rise_cnt++;
    end

    always @(sclk) sclk_toggles++;

    always @(negedge clk) begin
        if (csn !== 1'b1) csn_low_cnt++;
        if (csn === 1'b1) begin
            csn_hi_run++;
        end else begin
            if (csn_hi_run > 0) last_gap = csn_hi_run;
            csn_hi_run = 0;
        end
    end

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_count++;
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done actual=done_o high at cycle %0d required=no done", cyc);
            end else begin
                m_e = sbq.pop_front();
                check("rx_data", 32'(rx), 32'(m_e.rx));
                check("mosi_word", 32'(mosi_word), 32'(m_e.tx));
                check("done_cycle", cyc, m_e.done_cyc);
                check("rise_count", rise_cnt, 16);
            end
        end
    end

    always @(negedge clk) begin
        if (csclk === 1'b1) c_hi++;
        if (cdone === 1'b1) begin
            if (cq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL c_unexpected_done actual=done_o high at cycle %0d required=no done", cyc);
            end else begin
                c_e = cq.pop_front();
                check("c_rx_data", 32'(crx), 32'(c_e.rx));
                check("c_done_cycle", cyc, c_e.done_cyc);
                check("c_sclk_high", c_hi, 1);
                c_hi = 0;
            end
        end
    end

    int a;
    int dc0;

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        tx     = 16'h0;
        miso   = 1'b0;
        cstart = 1'b0;
        ctx    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_csn", 32'(csn), 1);
        check("rst_sclk", 32'(sclk), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rx", 32'(rx), 0);
        check("rst_done", 32'(done), 0);

        // Single transfer
        slave_word = 16'h3C5A;
        a = cyc;
        start = 1'b1;
        tx    = 16'hA5C3;
        sbq.push_back('{16'hA5C3, 16'h3C5A, a + 1033});
        @(negedge clk);
        start = 1'b0;
        repeat (1040) @(negedge clk);

        // Busy rejection
        dc0 = done_count;
        slave_word = 16'h0F0F;
        a = cyc;
        start = 1'b1;
        tx    = 16'h0001;
        sbq.push_back('{16'h0001, 16'h0F0F, a + 1033});
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        start = 1'b1;
        tx    = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (1000) @(negedge clk);
        check("busy_single_done", done_count - dc0, 1);

        // Back-to-back with start held high
        a = cyc;
        slave_word = 16'hC0DE;
        start = 1'b1;
        tx    = 16'h1234;
        sbq.push_back('{16'h1234, 16'hC0DE, a + 1033});
        sbq.push_back('{16'h5678, 16'hBEEF, a + 2066});
        repeat (10) @(negedge clk);
        tx         = 16'h5678;
        slave_word = 16'hBEEF;
        repeat (1024) @(negedge clk);
        start = 1'b0;
        repeat (1100) @(negedge clk);
        check("b2b_csn_gap", last_gap, 1);

        // Reset while SCLK is high in the first bit
        dc0 = done_count;
        a = cyc;
        start = 1'b1;
        tx    = 16'h8001;
        sbq.push_back('{16'h8001, 16'h0000, a + 1033});
        @(negedge clk);
        start = 1'b0;
        repeat (44) @(negedge clk);
        check("pre_rst_sclk", 32'(sclk), 1);
        check("pre_rst_mosi", 32'(mosi), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_csn", 32'(csn), 1);
        check("mid_rst_sclk", 32'(sclk), 0);
        check("mid_rst_mosi", 32'(mosi), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_rx", 32'(rx), 0);
        sbq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_csn", 32'(csn), 1);
        check("post_rst_busy", 32'(busy), 0);
        check("rst_no_done", done_count - dc0, 0);

        // Idle stability
        sclk_toggles = 0;
        csn_low_cnt  = 0;
        repeat (2000) @(negedge clk);
        check("idle_sclk_toggles", sclk_toggles, 0);
        check("idle_csn_low", csn_low_cnt, 0);

        // 1-bit minimal geometry with loopback
        c_hi = 0;
        a = cyc;
        cstart = 1'b1;
        ctx    = 1'b1;
        cq.push_back('{16'h0, 16'h0001, a + 5});
        @(negedge clk);
        cstart = 1'b0;
        repeat (10) @(negedge clk);
        c_hi = 0;
        a = cyc;
        cstart = 1'b1;
        ctx    = 1'b0;
        cq.push_back('{16'h0, 16'h0000, a + 5});
        @(negedge clk);
        cstart = 1'b0;
        repeat (10) @(negedge clk);

        check("sb_drained", sbq.size(), 0);
        check("c_sb_drained", cq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
